// File: rtl/sad_matcher_if.sv
// sad_matcher_if: start/threshold control, result, and the two lock-step read ports of sad_matcher
//   slave  : matcher side, drives read enables/addresses and busy/done/sad/match
//   master : controller/memory side, drives start/thresh and both read-data words
interface sad_matcher_if #(parameter int ADDR_W = 18, parameter int ACC_W = 32);
  logic              start;
  logic [ACC_W-1:0]  thresh;
  logic              img_r_en;
  logic [ADDR_W-1:0] img_r_add;
  logic [31:0]       img_r_data;
  logic              tpl_r_en;
  logic [ADDR_W-1:0] tpl_r_add;
  logic [31:0]       tpl_r_data;
  logic              busy;
  logic              done;
  logic [ACC_W-1:0]  sad;
  logic              match;
  modport slave (
    input  start, thresh, img_r_data, tpl_r_data,
    output img_r_en, img_r_add, tpl_r_en, tpl_r_add, busy, done, sad, match
  );
  modport master (
    output start, thresh, img_r_data, tpl_r_data,
    input  img_r_en, img_r_add, tpl_r_en, tpl_r_add, busy, done, sad, match
  );
endinterface

// File: rtl/sad_matcher.sv
// sad_matcher: sum of absolute byte differences between an N-word image vector and a stored template
//   clk   : system clock
//   reset : asynchronous active-low reset
//   bus   : sad_matcher_if.slave (start/thresh in, lock-step img/tpl read ports, busy/done/sad/match out)
module sad_matcher #(
  parameter int N      = 1024,
  parameter int ADDR_W = 18,
  parameter int ACC_W  = 32
) (
  input logic          clk,
  input logic          reset,
  sad_matcher_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
  state_t            state, next;
  logic [ADDR_W-1:0] cnt;
  logic [ACC_W-1:0]  thr, acc, sad_q;
  logic              match_q, dv, av, last;
  logic [3:0][7:0]   ad;
  logic [9:0]        sum;
  assign last = cnt == ADDR_W'(N - 1);
  assign sum  = {2'b0, ad[0]} + {2'b0, ad[1]} + {2'b0, ad[2]} + {2'b0, ad[3]};
  always_comb begin
    next          = state;
    bus.img_r_en  = 1'b0;
    bus.img_r_add = '0;
    case (state)
      IDLE:    if (bus.start) next = READ;
      READ: begin
        bus.img_r_en  = 1'b1;
        bus.img_r_add = cnt;
        if (last) next = DRAIN;
      end
      // dv low means the final read data has already moved into the diff stage
      DRAIN:   if (!dv) next = DONE;
      default: next = IDLE;
    endcase
    bus.tpl_r_en  = bus.img_r_en;
    bus.tpl_r_add = bus.img_r_add;
    bus.busy      = state != IDLE;
    bus.done      = state == DONE;
    // results show the live accumulator during DONE, then the held copy
    bus.sad       = state == DONE ? acc : sad_q;
    bus.match     = state == DONE ? acc < thr : match_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      thr     <= '0;
      acc     <= '0;
      sad_q   <= '0;
      match_q <= 1'b0;
      dv      <= 1'b0;
      av      <= 1'b0;
      ad      <= '0;
    end else begin
      state <= next;
      dv    <= bus.img_r_en;
      av    <= dv;
      for (int i = 0; i < 4; i++)
        ad[i] <= bus.img_r_data[8*i +: 8] > bus.tpl_r_data[8*i +: 8]
               ? bus.img_r_data[8*i +: 8] - bus.tpl_r_data[8*i +: 8]
               : bus.tpl_r_data[8*i +: 8] - bus.img_r_data[8*i +: 8];
      if (state == IDLE && bus.start) begin
        thr <= bus.thresh;
        acc <= '0;
        cnt <= '0;
      end else begin
        if (state == READ) cnt <= last ? '0 : cnt + ADDR_W'(1);
        if (av) acc <= acc + ACC_W'(sum);
      end
      if (state == DONE) begin
        sad_q   <= acc;
        match_q <= acc < thr;
      end
    end
endmodule

// File: tb/tb_sad_matcher.sv
// tb_sad_matcher: self-checking bench for sad_matcher (N=1024 main instance plus an N=4 instance)
module tb_sad_matcher;
  localparam int N = 1024;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  sad_matcher_if #(.ADDR_W(18), .ACC_W(32)) m ();
  sad_matcher_if #(.ADDR_W(2), .ACC_W(32)) s ();
  sad_matcher #(.N(N), .ADDR_W(18), .ACC_W(32)) dut (.clk(clk), .reset(reset), .bus(m));
  sad_matcher #(.N(4), .ADDR_W(2), .ACC_W(32)) dut_s (.clk(clk), .reset(reset), .bus(s));
  logic [31:0] img_mem [N];
  logic [31:0] tpl_mem [N];
  int tests = 0;
  int fails = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask
  // registered-read memories with one cycle of latency
  always @(posedge clk) begin
    if (m.img_r_en) m.img_r_data <= img_mem[m.img_r_add[9:0]];
    if (m.tpl_r_en) m.tpl_r_data <= tpl_mem[m.tpl_r_add[9:0]];
    if (s.img_r_en) s.img_r_data <= 32'h0102_0304;
    if (s.tpl_r_en) s.tpl_r_data <= 32'h0403_0201;
  end
  function automatic longint ref_sad();
    longint r = 0;
    for (int k = 0; k < N; k++)
      for (int b = 0; b < 4; b++) begin
        int a = int'(img_mem[k][8*b +: 8]);
        int t = int'(tpl_mem[k][8*b +: 8]);
        r += (a > t) ? a - t : t - a;
      end
    return r;
  endfunction
  // run timeline model: k counts cycles from the first read cycle of a run
  bit     m_run = 0;
  int     m_k = 0;
  longint m_exp = 0, m_thr = 0, m_sad = 0;
  bit     m_match = 0;
  always @(posedge clk or negedge reset)
    if (!reset) begin
      m_run = 0; m_k = 0; m_sad = 0; m_match = 0;
    end else if (!m_run) begin
      if (m.start) begin
        m_run = 1; m_k = 0; m_thr = longint'(m.thresh); m_exp = ref_sad();
      end
    end else if (m_k == N + 2) begin
      m_run = 0; m_sad = m_exp; m_match = m_exp < m_thr;
    end else m_k++;
  int cyc = 0, en_cnt = 0, run_en = 0, last_en = 0, lat = 0, last_done = 0, gap = 0, done_cnt = 0;
  bit seen = 0;
  always @(negedge clk) begin
    bit en, dn;
    en = m_run && m_k < N;
    dn = m_run && m_k == N + 2;
    cyc++;
    chk("img_r_en", m.img_r_en, en);
    chk("tpl_r_en", m.tpl_r_en, en);
    chk("img_r_add", m.img_r_add, en ? m_k : 0);
    chk("tpl_r_add", m.tpl_r_add, en ? m_k : 0);
    chk("busy", m.busy, m_run);
    chk("done", m.done, dn);
    chk("sad", m.sad, dn ? m_exp : m_sad);
    chk("match", m.match, dn ? (m_exp < m_thr) : m_match);
    if (!reset) begin
      en_cnt = 0; seen = 0;
    end else begin
      if (m.img_r_en) begin
        if (!seen) begin seen = 1; gap = cyc - last_done; end
        en_cnt++; last_en = cyc;
      end
      if (m.done) begin
        done_cnt++; lat = cyc - last_en; run_en = en_cnt; en_cnt = 0; seen = 0; last_done = cyc;
      end
    end
  end
  int s_cyc = 0, s_en = 0, s_last = 0, s_lat = 0;
  always @(negedge clk) begin
    s_cyc++;
    if (s.img_r_en) begin
      chk("s_r_add", s.img_r_add, s_en);
      s_en++; s_last = s_cyc;
    end
    if (s.done) s_lat = s_cyc - s_last;
  end
  task automatic fill(input logic [31:0] iw, input logic [31:0] tw);
    for (int k = 0; k < N; k++) begin img_mem[k] = iw; tpl_mem[k] = tw; end
  endtask
  task automatic pulse_start(input logic [31:0] th);
    @(negedge clk); m.thresh = th; m.start = 1'b1;
    @(negedge clk); m.start = 1'b0;
  endtask
  task automatic wait_done(input int lim);
    int i = 0;
    while (!m.done && i < lim) begin @(negedge clk); i++; end
    chk("done_seen", m.done, 1);
    #1;
  endtask
  initial begin
    int d0;
    m.start = 1'b0; m.thresh = '0; s.start = 1'b0; s.thresh = '0;
    fill(32'hA5A5_A5A5, 32'hA5A5_A5A5);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", m.busy, 0);
    chk("rst_done", m.done, 0);
    chk("rst_sad", m.sad, 0);
    chk("rst_en", m.img_r_en, 0);
    chk("rst_s_busy", s.busy, 0);
    @(negedge clk); #2 reset = 1'b1;
    pulse_start(1); wait_done(N + 20);
    chk("ident_sad", m.sad, 0);
    chk("ident_match", m.match, 1);
    chk("ident_en_cnt", run_en, N);
    chk("ident_lat", lat, 3);
    fill(32'hFFFF_FFFF, 32'h0000_0000);
    pulse_start(1044480); wait_done(N + 20);
    chk("max_sad", m.sad, 1044480);
    chk("max_eq_match", m.match, 0);
    pulse_start(1044481); wait_done(N + 20);
    chk("max_gt_match", m.match, 1);
    fill(32'h0000_00FF, 32'h0000_0100);
    pulse_start(0); wait_done(N + 20);
    chk("lane_sad", m.sad, 262144);
    chk("lane_match", m.match, 0);
    d0 = done_cnt;
    pulse_start(300000);
    repeat (8) @(negedge clk);
    m.thresh = 0; m.start = 1'b1; @(negedge clk); m.start = 1'b0;
    repeat (489) @(negedge clk);
    m.start = 1'b1; @(negedge clk); m.start = 1'b0;
    wait_done(N + 20);
    chk("busy_start_sad", m.sad, 262144);
    chk("busy_start_match", m.match, 1);
    chk("busy_start_en", run_en, N);
    repeat (20) @(negedge clk);
    #1;
    chk("busy_start_dones", done_cnt - d0, 1);
    chk("busy_start_idle", m.busy, 0);
    fill(32'hFFFF_FFFF, 32'h0000_0000);
    @(negedge clk); m.thresh = 2000000; m.start = 1'b1;
    wait_done(N + 20);
    chk("held1_sad", m.sad, 1044480);
    chk("held1_match", m.match, 1);
    fill(32'h0000_00FF, 32'h0000_0100);
    m.thresh = 0;
    @(negedge clk);
    @(negedge clk);
    m.start = 1'b0;
    #1;
    chk("held_sad_kept", m.sad, 1044480);
    chk("held_match_kept", m.match, 1);
    wait_done(N + 20);
    chk("held2_sad", m.sad, 262144);
    chk("held2_match", m.match, 0);
    chk("held2_gap", gap, 2);
    chk("held2_en", run_en, N);
    fill(32'h1234_5679, 32'h1234_5678);
    pulse_start(2000);
    for (int i = 0; i < N && !(m.img_r_en && m.img_r_add == 300); i++) @(negedge clk);
    chk("rst_mid_reach", m.img_r_add, 300);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_busy", m.busy, 0);
    chk("rst_mid_en", m.img_r_en, 0);
    chk("rst_mid_add", m.img_r_add, 0);
    chk("rst_mid_sad", m.sad, 0);
    chk("rst_mid_match", m.match, 0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    pulse_start(2000); wait_done(N + 20);
    chk("byte0_sad", m.sad, 1024);
    chk("byte0_match", m.match, 1);
    chk("byte0_en", run_en, N);
    @(negedge clk); s.thresh = 33; s.start = 1'b1;
    @(negedge clk); s.start = 1'b0;
    for (int i = 0; i < 20 && !s.done; i++) @(negedge clk);
    #1;
    chk("small_done", s.done, 1);
    chk("small_sad", s.sad, 32);
    chk("small_match", s.match, 1);
    chk("small_en", s_en, 4);
    chk("small_lat", s_lat, 3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
